// File: rtl/stream_seq_checker.sv
// AXI-Stream sequence checker: counts beats, data-sequence and tlast-framing errors until a terminal word.
// Optional macro SEQ_CHECK_BACKPRESSURE_EN adds LFSR-driven pseudo-random tready stalls.
module stream_seq_checker #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    FRAME_SIZE     = 4,
   parameter logic [DATA_WIDTH-1:0] START_VALUE    = '0,
   parameter logic [DATA_WIDTH-1:0] TERMINAL_VALUE = '1,
   parameter int                    RESYNC         = 1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [31:0]           beat_count,
   output logic [15:0]           data_err_count,
   output logic [15:0]           last_err_count,
   output logic                  err_flag,
   output logic [DATA_WIDTH-1:0] first_err_exp,
   output logic [DATA_WIDTH-1:0] first_err_act,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [15:0]           LAST_POS = 16'(FRAME_SIZE - 1);
   localparam logic [DATA_WIDTH-1:0] ONE_W    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [DATA_WIDTH-1:0] first_exp_q, first_exp_d;
   logic [DATA_WIDTH-1:0] first_act_q, first_act_d;
   logic [15:0]           pos_q, pos_d;
   logic [31:0]           beat_q, beat_d;
   logic [15:0]           derr_q, derr_d;
   logic [15:0]           lerr_q, lerr_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;
   logic                  tready_q, tready_d;

   logic accept;
   logic last_exp;
   logic data_mis;
   logic last_mis;

`ifdef SEQ_CHECK_BACKPRESSURE_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running every cycle.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
`endif

   assign accept   = s_axis_tvalid & tready_q;
   assign last_exp = (pos_q == LAST_POS);
   assign data_mis = accept && (s_axis_tdata != exp_q);
   assign last_mis = accept && (s_axis_tlast != last_exp);

   // Next-state computation for the FSM, counters and error capture.
   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      first_exp_d = first_exp_q;
      first_act_d = first_act_q;
      pos_d       = pos_q;
      beat_d      = beat_q;
      derr_d      = derr_q;
      lerr_d      = lerr_q;
      err_d       = err_q;
      if (accept) begin
         beat_d = beat_q + 32'd1;
         if (RESYNC != 0) begin
            exp_d = s_axis_tdata + ONE_W;
         end else begin
            exp_d = exp_q + ONE_W;
         end
         if (last_exp) begin
            pos_d = 16'd0;
         end else begin
            pos_d = pos_q + 16'd1;
         end
         if (data_mis) begin
            err_d = 1'b1;
            // The saturating count only reads zero before the first mismatch.
            if (derr_q == 16'd0) begin
               first_exp_d = exp_q;
               first_act_d = s_axis_tdata;
            end else begin
               first_exp_d = first_exp_q;
               first_act_d = first_act_q;
            end
            if (derr_q != 16'hFFFF) begin
               derr_d = derr_q + 16'd1;
            end else begin
               derr_d = derr_q;
            end
         end else begin
            derr_d = derr_q;
         end
         if (last_mis) begin
            err_d = 1'b1;
            if (lerr_q != 16'hFFFF) begin
               lerr_d = lerr_q + 16'd1;
            end else begin
               lerr_d = lerr_q;
            end
         end else begin
            lerr_d = lerr_q;
         end
         case (state_q)
            IDLE:    state_d = (s_axis_tdata == TERMINAL_VALUE) ? DONE : RUN;
            RUN:     state_d = (s_axis_tdata == TERMINAL_VALUE) ? DONE : RUN;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
      done_d = (state_d == DONE);
`ifdef SEQ_CHECK_BACKPRESSURE_EN
      tready_d = (state_d != DONE) & lfsr_d[0];
`else
      tready_d = (state_d != DONE);
`endif
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         exp_q       <= START_VALUE;
         first_exp_q <= '0;
         first_act_q <= '0;
         pos_q       <= 16'd0;
         beat_q      <= 32'd0;
         derr_q      <= 16'd0;
         lerr_q      <= 16'd0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         tready_q    <= 1'b0;
`ifdef SEQ_CHECK_BACKPRESSURE_EN
         lfsr_q      <= 16'hACE1;
`endif
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         first_exp_q <= first_exp_d;
         first_act_q <= first_act_d;
         pos_q       <= pos_d;
         beat_q      <= beat_d;
         derr_q      <= derr_d;
         lerr_q      <= lerr_d;
         err_q       <= err_d;
         done_q      <= done_d;
         tready_q    <= tready_d;
`ifdef SEQ_CHECK_BACKPRESSURE_EN
         lfsr_q      <= lfsr_d;
`endif
      end
   end

   assign s_axis_tready  = tready_q;
   assign beat_count     = beat_q;
   assign data_err_count = derr_q;
   assign last_err_count = lerr_q;
   assign err_flag       = err_q;
   assign first_err_exp  = first_exp_q;
   assign first_err_act  = first_act_q;
   assign done           = done_q;

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed bench for stream_seq_checker: an 8-bit RESYNC=1 instance and a 16-bit RESYNC=0 instance share stimulus.
module tb_stream_seq_checker;

   logic        aclk;
   logic        aresetn;
   logic [15:0] tdata16;
   logic        tvalid;
   logic        tlast;

   logic        tready1, err1, done1;
   logic [31:0] beat1;
   logic [15:0] derr1, lerr1;
   logic [7:0]  fexp1, fact1;

   logic        tready2, err2, done2;
   logic [31:0] beat2;
   logic [15:0] derr2, lerr2;
   logic [15:0] fexp2, fact2;

   int total;
   int bad;
   int low_seen;

   stream_seq_checker #(.DATA_WIDTH(8), .RESYNC(1)) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata16[7:0]),
      .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready1),
      .beat_count(beat1), .data_err_count(derr1), .last_err_count(lerr1),
      .err_flag(err1), .first_err_exp(fexp1), .first_err_act(fact1), .done(done1)
   );

   stream_seq_checker #(.DATA_WIDTH(16), .RESYNC(0)) dut2 (
      .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata16),
      .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready2),
      .beat_count(beat2), .data_err_count(derr2), .last_err_count(lerr2),
      .err_flag(err2), .first_err_exp(fexp2), .first_err_act(fact2), .done(done2)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic send(input logic [15:0] d, input logic l, input bit use2);
      bit ok;
      int n;
      @(negedge aclk);
      tdata16 = d;
      tlast   = l;
      tvalid  = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         ok = use2 ? tready2 : tready1;
         if (!ok) low_seen++;
         @(posedge aclk);
         if (!ok) @(negedge aclk);
         n++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_timeout data=%h not accepted within 200 cycles", d);
      end
   endtask

   task automatic idle();
      @(negedge aclk);
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge aclk);
      tvalid  = 1'b0;
      tlast   = 1'b0;
      aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge aclk);
      total++; if (tready1 !== 1'b0)     begin bad++; $display("FAIL rst_tready got=%b want=0", tready1); end
      total++; if (beat1 !== 32'd0)      begin bad++; $display("FAIL rst_beat got=%0d want=0", beat1); end
      total++; if (derr1 !== 16'd0 || lerr1 !== 16'd0) begin bad++; $display("FAIL rst_errs got=%0d/%0d want=0/0", derr1, lerr1); end
      total++; if (err1 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b/%b want=0/0", err1, done1); end
      total++; if (fexp1 !== 8'h00 || fact1 !== 8'h00) begin bad++; $display("FAIL rst_capture got=%h/%h want=00/00", fexp1, fact1); end
      aresetn = 1'b1;
      @(negedge aclk);
`ifndef SEQ_CHECK_BACKPRESSURE_EN
      total++; if (tready1 !== 1'b1) begin bad++; $display("FAIL release_tready got=%b want=1", tready1); end
`endif
      total++; if (done1 !== 1'b0) begin bad++; $display("FAIL release_done got=%b want=0", done1); end
   endtask

   task automatic test_full_run();
      do_reset();
      for (int i = 0; i < 256; i++) send(16'(i), (i % 4) == 3, 1'b0);
      idle();
      total++; if (beat1 !== 32'd256) begin bad++; $display("FAIL full_beat got=%0d want=256", beat1); end
      total++; if (derr1 !== 16'd0 || lerr1 !== 16'd0) begin bad++; $display("FAIL full_errs got=%0d/%0d want=0/0", derr1, lerr1); end
      total++; if (done1 !== 1'b1) begin bad++; $display("FAIL full_done got=%b want=1", done1); end
      total++; if (tready1 !== 1'b0) begin bad++; $display("FAIL full_tready got=%b want=0", tready1); end
      // Offer more beats while DONE; nothing may change.
      tdata16 = 16'h0005;
      tlast   = 1'b1;
      tvalid  = 1'b1;
      repeat (5) @(negedge aclk);
      tvalid = 1'b0;
      total++; if (beat1 !== 32'd256 || derr1 !== 16'd0 || lerr1 !== 16'd0 || err1 !== 1'b0)
         begin bad++; $display("FAIL done_frozen got beat=%0d derr=%0d lerr=%0d err=%b want 256/0/0/0", beat1, derr1, lerr1, err1); end
   endtask

   task automatic test_resync();
      logic [15:0] seq [6];
      seq = '{16'd0, 16'd1, 16'd2, 16'd7, 16'd8, 16'd9};
      do_reset();
      for (int i = 0; i < 6; i++) send(seq[i], (i % 4) == 3, 1'b0);
      idle();
      total++; if (derr1 !== 16'd1) begin bad++; $display("FAIL resync1_derr got=%0d want=1", derr1); end
      total++; if (fexp1 !== 8'h03 || fact1 !== 8'h07) begin bad++; $display("FAIL resync1_capture got=%h/%h want=03/07", fexp1, fact1); end
      total++; if (lerr1 !== 16'd0 || err1 !== 1'b1 || beat1 !== 32'd6) begin bad++; $display("FAIL resync1_misc got lerr=%0d err=%b beat=%0d want 0/1/6", lerr1, err1, beat1); end
      total++; if (derr2 !== 16'd3) begin bad++; $display("FAIL resync0_derr got=%0d want=3", derr2); end
      total++; if (fexp2 !== 16'h0003 || fact2 !== 16'h0007) begin bad++; $display("FAIL resync0_capture got=%h/%h want=0003/0007", fexp2, fact2); end
   endtask

   task automatic test_tlast();
      do_reset();
      for (int i = 0; i < 4; i++) send(16'(i), i == 2, 1'b0);
      idle();
      total++; if (lerr1 !== 16'd2) begin bad++; $display("FAIL tlast_lerr got=%0d want=2", lerr1); end
      total++; if (err1 !== 1'b1) begin bad++; $display("FAIL tlast_err got=%b want=1", err1); end
      total++; if (derr1 !== 16'd0) begin bad++; $display("FAIL tlast_derr got=%0d want=0", derr1); end
   endtask

   task automatic test_both_mismatch();
      do_reset();
      send(16'd0, 1'b0, 1'b0);
      send(16'd1, 1'b0, 1'b0);
      send(16'd5, 1'b1, 1'b0);
      // One edge after the offending beat, both counters must have moved.
      @(negedge aclk);
      tvalid = 1'b0;
      total++; if (derr1 !== 16'd1 || lerr1 !== 16'd1) begin bad++; $display("FAIL both_counts got=%0d/%0d want=1/1", derr1, lerr1); end
      total++; if (beat1 !== 32'd3) begin bad++; $display("FAIL both_beat got=%0d want=3", beat1); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 6; i++) send(16'(i), (i % 4) == 3, 1'b0);
      idle();
      #2 aresetn = 1'b0;
      #1;
      total++; if (beat1 !== 32'd0 || tready1 !== 1'b0) begin bad++; $display("FAIL async_reset got beat=%0d tready=%b want 0/0", beat1, tready1); end
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      for (int i = 0; i < 8; i++) send(16'(i), (i % 4) == 3, 1'b0);
      idle();
      total++; if (beat1 !== 32'd8) begin bad++; $display("FAIL restart_beat got=%0d want=8", beat1); end
      total++; if (derr1 !== 16'd0 || lerr1 !== 16'd0 || err1 !== 1'b0) begin bad++; $display("FAIL restart_errs got=%0d/%0d/%b want=0/0/0", derr1, lerr1, err1); end
   endtask

`ifdef SEQ_CHECK_BACKPRESSURE_EN
   task automatic test_backpressure();
      do_reset();
      low_seen = 0;
      for (int i = 0; i < 300; i++) send(16'(i), (i % 4) == 3, 1'b1);
      idle();
      total++; if (beat2 !== 32'd300) begin bad++; $display("FAIL bp_beat got=%0d want=300", beat2); end
      total++; if (derr2 !== 16'd0 || lerr2 !== 16'd0) begin bad++; $display("FAIL bp_errs got=%0d/%0d want=0/0", derr2, lerr2); end
      total++; if ((low_seen > 0) !== 1'b1) begin bad++; $display("FAIL bp_stall got=%0d low cycles want>0", low_seen); end
   endtask
`endif

   initial begin
      total    = 0;
      bad      = 0;
      low_seen = 0;
      aresetn  = 1'b0;
      tvalid   = 1'b0;
      tlast    = 1'b0;
      tdata16  = 16'd0;
      test_reset();
      test_full_run();
      test_resync();
      test_tlast();
      test_both_mismatch();
      test_mid_reset();
`ifdef SEQ_CHECK_BACKPRESSURE_EN
      test_backpressure();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_seq_checker.md
STREAM_SEQ_CHECKER -- requirements
Module: stream_seq_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the checked data word.
REQ-002 SHALL have parameter FRAME_SIZE, default 4: beats per frame; tlast expected on beat FRAME_SIZE-1 of each frame; legal range 1..65535.
REQ-003 SHALL have parameter START_VALUE, default 0: first expected data word.
REQ-004 SHALL have parameter TERMINAL_VALUE, default all-ones (2^DATA_WIDTH-1): an accepted word equal to this ends the run.
REQ-005 SHALL have parameter RESYNC, default 1: 1 means reload the expected value from received data after a mismatch; 0 means keep counting independently.
REQ-006 SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port s_axis_tdata, input, DATA_WIDTH bits: stream data under check.
REQ-009 SHALL have port s_axis_tvalid, input, 1 bit: upstream valid.
REQ-010 SHALL have port s_axis_tlast, input, 1 bit: upstream frame end.
REQ-011 SHALL have port s_axis_tready, output, 1 bit: checker ready.
REQ-012 SHALL have port beat_count, output, 32 bits: accepted beats, wraps modulo 2^32.
REQ-013 SHALL have port data_err_count, output, 16 bits: data mismatches, saturating at 0xFFFF.
REQ-014 SHALL have port last_err_count, output, 16 bits: tlast mismatches, saturating at 0xFFFF.
REQ-015 SHALL have port err_flag, output, 1 bit: sticky; set on any mismatch.
REQ-016 SHALL have ports first_err_exp and first_err_act, output, DATA_WIDTH bits each: expected and actual word of the first data mismatch.
REQ-017 SHALL have port done, output, 1 bit: sticky; run finished.

Function
REQ-018 A beat SHALL be accepted only in a cycle where s_axis_tvalid and s_axis_tready are both 1 at the rising edge.
REQ-019 The FSM SHALL have states IDLE, RUN and DONE. It leaves reset in IDLE, goes IDLE->RUN on the first accepted beat, and goes RUN->DONE on an accepted beat whose word equals TERMINAL_VALUE. DONE is exited only by reset.
REQ-020 In DONE, s_axis_tready SHALL be 0 and no counter, flag or capture register SHALL change.
REQ-021 The expected value SHALL start at START_VALUE and, after each accepted beat, become the accepted data+1 (RESYNC=1) or the expected value+1 (RESYNC=0), modulo 2^DATA_WIDTH (0xFF wraps to 0x00).
REQ-022 A data mismatch SHALL be an accepted word not equal to the expected value; it increments data_err_count and sets err_flag.
REQ-023 first_err_exp and first_err_act SHALL load only on the first data mismatch after reset and then hold.
REQ-024 A frame position counter (0..FRAME_SIZE-1) SHALL advance on each accepted beat and wrap to 0 after FRAME_SIZE-1.
REQ-025 A tlast mismatch SHALL be s_axis_tlast differing from (position == FRAME_SIZE-1) on an accepted beat; it increments last_err_count and sets err_flag.
REQ-026 A beat with both a data mismatch and a tlast mismatch SHALL increment both counters in the same cycle.
REQ-027 All outputs SHALL be registered and SHALL reflect an accepted beat on the following rising edge (latency 1).
REQ-028 The terminal beat SHALL itself be checked and counted; done rises on the same edge as that beat's counter updates.

Reset
REQ-029 While aresetn=0 (asynchronous): s_axis_tready=0; all counts, err_flag, done and capture registers are 0; state is IDLE; expected=START_VALUE; position=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no error recorded; after release the next beat is frame position 0.

Configuration
REQ-031 Macro SEQ_CHECK_BACKPRESSURE_EN: when defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset) advances every cycle, and s_axis_tready = not DONE and LFSR bit 0, which exercises upstream stalls.
REQ-032 When SEQ_CHECK_BACKPRESSURE_EN is undefined, s_axis_tready SHALL be 1 in every non-DONE cycle after reset release and no LFSR logic SHALL exist.

Verification
REQ-033 Defaults; beats 0x00..0xFF with tlast every 4th -> beat_count=256, both error counts 0, done=1, tready=0 afterwards.
REQ-034 Sequence 0,1,2,7,8,9 with correct tlast, RESYNC=1 -> data_err_count=1, first_err_exp=0x03, first_err_act=0x07.
REQ-035 Same sequence with RESYNC=0 -> data_err_count=3.
REQ-036 tlast on beat 2 instead of beat 3 -> last_err_count=2, err_flag=1, data_err_count=0.
REQ-037 Reset pulsed after beat 0x05, then restart from 0x00 -> counts restart from 0, no errors.
REQ-038 Macro defined; 300 beats -> every beat accepted exactly once despite stalls, no errors, tready observed low at least once before done.
